// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Multi-cycle ALU execution unit between decode/register-read and writeback.
// Logic and arithmetic ops finish in one cycle. Shifts move one bit per cycle
// so the datapath never needs a barrel shifter.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   operation request valid
//   in_ready   unit can accept an operation (IDLE only)
//   control    4-bit ALU control code from decode
//   a, b       operands; shifts use b[SHW-1:0] as the shift amount
//   out_valid  result valid (DONE only)
//   out_ready  downstream accepts the result
//   result     registered result
//   zero       result == 0, registered with result
//   illegal    unsupported control code, result forced to 0
//
// state  | meaning
// IDLE   | waiting for a request, in_ready=1
// SHIFT  | iterative shift in progress, one bit per cycle
// DONE   | result held, out_valid=1, waiting for out_ready
module alu_exec_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SLT  = 4'b0100;
   localparam logic [3:0] OP_SLTU = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1010;

   state_t           state, state_nx;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] shift_nx;
   logic [SHW-1:0]   cnt;
   logic [SHW-1:0]   shamt;
   logic [3:0]       op_r;
   logic             zero_r;
   logic             illegal_r;
   logic             is_shift;
   logic             illegal_c;
   logic             start_shift;

   assign shamt       = b[SHW-1:0];
   assign start_shift = is_shift && (shamt != '0);

   // Single-cycle result. A shift by zero simply returns a; X/Z control
   // codes fall into the default branch and are reported illegal.
   always_comb begin
      alu_res   = '0;
      is_shift  = 1'b0;
      illegal_c = 1'b0;
      case (control)
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_XOR:  alu_res = a ^ b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLL, OP_SRL, OP_SRA: begin
            is_shift = 1'b1;
            alu_res  = a;
         end
         default: begin
            illegal_c = 1'b1;
            alu_res   = '0;
         end
      endcase
   end

   always_comb begin
      case (op_r)
         OP_SLL:  shift_nx = {work[WIDTH-2:0], 1'b0};
         OP_SRA:  shift_nx = {work[WIDTH-1], work[WIDTH-1:1]};
         default: shift_nx = {1'b0, work[WIDTH-1:1]};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (in_valid) state_nx = start_shift ? S_SHIFT : S_DONE;
         end
         S_SHIFT: begin
            // cnt==1 means the final bit moves on this edge
            if (cnt == SHW'(1)) state_nx = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         work      <= '0;
         cnt       <= '0;
         op_r      <= '0;
         zero_r    <= 1'b0;
         illegal_r <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_r      <= control;
                  illegal_r <= illegal_c;
                  if (start_shift) begin
                     work <= a;
                     cnt  <= shamt;
                  end else begin
                     work   <= alu_res;
                     zero_r <= (alu_res == '0);
                  end
               end
            end
            S_SHIFT: begin
               work <= shift_nx;
               cnt  <= cnt - SHW'(1);
               if (cnt == SHW'(1)) zero_r <= (shift_nx == '0);
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign result    = work;
   assign zero      = zero_r;
   assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  control;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .control(control), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] r;
      logic        z;
      logic        il;
      int          acc;
      int          lat;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares each newly presented result against the scoreboard,
   // and checks that a held result stays put under backpressure.
   logic        prev_valid = 1'b0;
   logic [31:0] held_r;
   always @(negedge clk) begin
      if (reset_n === 1'b1 && out_valid === 1'b1) begin
         if (!prev_valid) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got result 0x%08h with no pending op (cycle %0d)", result, cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("result", result, e.r);
               chk("zero", {31'b0, zero}, {31'b0, e.z});
               chk("illegal", {31'b0, illegal}, {31'b0, e.il});
               chk("latency", cyc - e.acc, e.lat);
               chk("in_ready_in_done", {31'b0, in_ready}, 32'd0);
            end
            held_r = result;
         end else begin
            chk("result_stable", result, held_r);
            chk("in_ready_held_low", {31'b0, in_ready}, 32'd0);
         end
      end
      prev_valid = (reset_n === 1'b1) && (out_valid === 1'b1);
   end

   task automatic issue(input logic [3:0] ctl, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input logic ez, input logic eil,
                        input int lat, input bit push);
      int n;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      control  = ctl;
      a        = av;
      b        = bv;
      n = 0;
      while (in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: in_ready stayed low for %0d cycles", n);
      end
      e.r = er; e.z = ez; e.il = eil; e.acc = cyc; e.lat = lat;
      if (push) q.push_back(e);
      @(negedge clk);
      // Scramble inputs after accept; the unit must not look at them again.
      in_valid = 1'b0;
      control  = 4'b1111;
      a        = $urandom;
      b        = $urandom;
   endtask

   task automatic drain;
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid === 1'b1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d results still pending", q.size());
      end
   endtask

   initial begin
      int n;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      control   = 4'b0000;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", {31'b0, zero}, 32'd0);
      chk("rst_illegal", {31'b0, illegal}, 32'd0);

      // ctl, a, b, result, zero, illegal, latency
      issue(4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b1);
      issue(4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 1'b1);
      issue(4'b0100, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1, 1'b1);
      issue(4'b0101, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1, 1'b1);
      issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1, 1'b1);
      issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 1, 1'b1);
      issue(4'b1010, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0, 32, 1'b1);
      issue(4'b0011, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1, 1'b1);
      issue(4'b0011, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 1'b0, 1'b0, 5, 1'b1);
      issue(4'b1000, 32'h8000_0000, 32'hFFFF_FFE4, 32'h0800_0000, 1'b0, 1'b0, 5, 1'b1);
      issue(4'b1010, 32'h4000_0000, 32'h0000_0001, 32'h2000_0000, 1'b0, 1'b0, 2, 1'b1);
      issue(4'b0011, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 2, 1'b1);
      issue(4'b1111, 32'd3, 32'd4, 32'h0, 1'b1, 1'b1, 1, 1'b1);
      issue(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1, 1'b1);
      issue(4'b1001, 32'd3, 32'd4, 32'h0, 1'b1, 1'b1, 1, 1'b1);
      drain();

      // Backpressure on an XOR result
      @(negedge clk);
      out_ready = 1'b0;
      issue(4'b0111, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0, 1'b0, 1, 1'b1);
      n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid_seen", {31'b0, out_valid}, 32'd1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
         chk("bp_result", result, 32'h0F0F_F0F0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
      chk("bp_out_valid_after", {31'b0, out_valid}, 32'd0);
      out_ready = 1'b1;

      // Reset in the middle of a 10-bit SRL: no result may appear.
      issue(4'b1000, 32'h8000_0000, 32'd10, 32'h0020_0000, 1'b0, 1'b0, 11, 1'b0);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("mid_rst_result", result, 32'd0);
      chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      repeat (15) @(negedge clk);
      chk("mid_rst_no_valid", {31'b0, out_valid}, 32'd0);
      issue(4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 1'b1);
      drain();

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
